// File: rtl/vga_pkg.sv
// Shared timing defaults, test-pattern codes and axis sizing helpers for the
// VGA raster timing generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_GRID  = 2'd1;
    localparam logic [1:0] PAT_WHITE = 2'd2;
    localparam logic [1:0] PAT_BLACK = 2'd3;

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int axis_width(input int act, input int fp, input int sync, input int bp);
        return $clog2(axis_total(act, fp, sync, bp));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = axis_width(ACTIVE, FP, SYNC, BP)
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_active,
    output logic         in_sync
);

    if (ACTIVE < 1 || SYNC < 1) begin : g_bad_params
        $error("vga_axis_counter: ACTIVE and SYNC must both be non-zero");
    end

    // Region bounds are all inclusive and <= TOTAL-1, so they fit in W bits.
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_LAST   = W'(ACTIVE - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] ONE        = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last_s;

    assign at_last_s = (cnt_q == LAST);

    // Next count: advance on inc, wrap to zero after the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            if (at_last_s) begin
                cnt_d = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign wrap      = inc && at_last_s;
    assign in_active = (cnt_q <= ACT_LAST);
    assign in_sync   = (cnt_q >= SYNC_FIRST) && (cnt_q <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a frame-synchronous
// test-pattern source and a single registered output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 1,
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int H_W     = axis_width(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_W     = axis_width(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               en,
    input  logic [1:0]         pattern,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               active,
    output logic [H_W-1:0]     pix_x,
    output logic [V_W-1:0]     pix_y,
    output logic               line_start,
    output logic               frame_start
);

    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $error("vga_timing_gen: H_ACTIVE must be a multiple of 8 for colour bars");
    end

    localparam int BAR_W = H_ACTIVE / 8;

    logic [H_W-1:0] h_cnt_s;
    logic [V_W-1:0] v_cnt_s;
    logic           h_wrap_s, h_act_s, h_sync_s;
    logic           v_wrap_unused_s, v_act_s, v_sync_s;
    logic           v_inc_s;

    assign v_inc_s = en && h_wrap_s;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk(clk), .nRst(nRst), .inc(en),
        .cnt(h_cnt_s), .wrap(h_wrap_s), .in_active(h_act_s), .in_sync(h_sync_s)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk(clk), .nRst(nRst), .inc(v_inc_s),
        .cnt(v_cnt_s), .wrap(v_wrap_unused_s), .in_active(v_act_s), .in_sync(v_sync_s)
    );

    logic               at_origin_s;
    logic               active_s;
    logic [1:0]         eff_pat_s;
    logic [2:0]         bar_s;
    logic               grid_s;
    logic [COLOR_W-1:0] r_s, g_s, b_s;

    logic [1:0]         pat_q, pat_d;
    logic               hs_q, hs_d, vs_q, vs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               act_q, act_d;
    logic [H_W-1:0]     x_q, x_d;
    logic [V_W-1:0]     y_q, y_d;
    logic               ls_q, ls_d, fs_q, fs_d;

    assign at_origin_s = (h_cnt_s == {H_W{1'b0}}) && (v_cnt_s == {V_W{1'b0}});
    assign active_s    = h_act_s && v_act_s;
    // The origin pixel already uses the pattern captured on that same cycle.
    assign eff_pat_s   = at_origin_s ? pattern : pat_q;
    assign grid_s      = ((32'(h_cnt_s) & 32'hF) == 32'd0) || ((32'(v_cnt_s) & 32'hF) == 32'd0);

    // Colour-bar index: number of bar boundaries at or left of h.
    always_comb begin
        bar_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt_s >= H_W'(k * BAR_W)) begin
                bar_s = 3'(k);
            end else begin
                bar_s = bar_s;
            end
        end
    end

    // Pattern colour mux, blanked outside the visible window.
    always_comb begin
        r_s = {COLOR_W{1'b0}};
        g_s = {COLOR_W{1'b0}};
        b_s = {COLOR_W{1'b0}};
        case (eff_pat_s)
            PAT_BARS: begin
                r_s = {COLOR_W{bar_s[2]}};
                g_s = {COLOR_W{bar_s[1]}};
                b_s = {COLOR_W{bar_s[0]}};
            end
            PAT_GRID: begin
                r_s = {COLOR_W{grid_s}};
                g_s = {COLOR_W{grid_s}};
                b_s = {COLOR_W{grid_s}};
            end
            PAT_WHITE: begin
                r_s = {COLOR_W{1'b1}};
                g_s = {COLOR_W{1'b1}};
                b_s = {COLOR_W{1'b1}};
            end
            PAT_BLACK: begin
                r_s = {COLOR_W{1'b0}};
                g_s = {COLOR_W{1'b0}};
                b_s = {COLOR_W{1'b0}};
            end
            default: begin
                r_s = {COLOR_W{1'b0}};
                g_s = {COLOR_W{1'b0}};
                b_s = {COLOR_W{1'b0}};
            end
        endcase
        if (!active_s) begin
            r_s = {COLOR_W{1'b0}};
            g_s = {COLOR_W{1'b0}};
            b_s = {COLOR_W{1'b0}};
        end else begin
            r_s = r_s;
        end
    end

    // Output-stage next state: load on en, otherwise hold; strobes self-clear.
    always_comb begin
        pat_d = pat_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
        act_d = act_q;
        x_d   = x_q;
        y_d   = y_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (en) begin
            pat_d = eff_pat_s;
            hs_d  = h_sync_s ? HS_POL : ~HS_POL;
            vs_d  = v_sync_s ? VS_POL : ~VS_POL;
            r_d   = r_s;
            g_d   = g_s;
            b_d   = b_s;
            act_d = active_s;
            x_d   = h_cnt_s;
            y_d   = v_cnt_s;
            ls_d  = (h_cnt_s == {H_W{1'b0}});
            fs_d  = at_origin_s;
        end else begin
            pat_d = pat_q;
        end
    end

    // Pattern shadow and registered outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pat_q <= PAT_BARS;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            r_q   <= {COLOR_W{1'b0}};
            g_q   <= {COLOR_W{1'b0}};
            b_q   <= {COLOR_W{1'b0}};
            act_q <= 1'b0;
            x_q   <= {H_W{1'b0}};
            y_q   <= {V_W{1'b0}};
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            pat_q <= pat_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            act_q <= act_d;
            x_q   <= x_d;
            y_q   <= y_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign vga_h_sync  = hs_q;
    assign vga_v_sync  = vs_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign active      = act_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x8 raster, with active-low and
// active-high sync instances driven in lockstep.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       ls;
        logic       fs;
        logic [0:0] r;
        logic [0:0] g;
        logic [0:0] b;
        logic [3:0] x;
        logic [2:0] y;
    } out_t;

    logic       clk = 1'b0;
    logic       nRst;
    logic       en;
    logic [1:0] pattern;

    logic       hs0, vs0, act0, ls0, fs0;
    logic [0:0] r0, g0, b0;
    logic [3:0] x0;
    logic [2:0] y0;
    logic       hs1, vs1, act1, ls1, fs1;
    logic [0:0] r1, g1, b1;
    logic [3:0] x1;
    logic [2:0] y1;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(1)
    ) dut (
        .clk(clk), .nRst(nRst), .en(en), .pattern(pattern),
        .vga_h_sync(hs0), .vga_v_sync(vs0), .R(r0), .G(g0), .B(b0),
        .active(act0), .pix_x(x0), .pix_y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(1)
    ) dut_pos (
        .clk(clk), .nRst(nRst), .en(en), .pattern(pattern),
        .vga_h_sync(hs1), .vga_v_sync(vs1), .R(r1), .G(g1), .B(b1),
        .active(act1), .pix_x(x1), .pix_y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_fs = -1;
    int   period = 0;
    int   mh = 0;
    int   mv = 0;
    logic [1:0] mpat = 2'd0;
    out_t last_exp;
    out_t sb[$];

    function automatic out_t reset_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Reference pixel for active-low syncs, straight from the raster description.
    function automatic out_t model_pix(input int h, input int v, input logic [1:0] pat);
        out_t o;
        int   bar;
        logic on;
        o     = '0;
        o.hs  = !(h >= HA + HF && h < HA + HF + HS);
        o.vs  = !(v >= VA + VF && v < VA + VF + VS);
        o.act = (h < HA) && (v < VA);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.x   = 4'(h);
        o.y   = 3'(v);
        bar   = h / (HA / 8);
        case (pat)
            2'd0: begin
                o.r = 1'(bar >> 2);
                o.g = 1'(bar >> 1);
                o.b = 1'(bar);
            end
            2'd1: begin
                on  = (h % 16 == 0) || (v % 16 == 0);
                o.r = on; o.g = on; o.b = on;
            end
            2'd2: begin
                o.r = 1'b1; o.g = 1'b1; o.b = 1'b1;
            end
            default: begin
                o.r = 1'b0; o.g = 1'b0; o.b = 1'b0;
            end
        endcase
        if (!o.act) begin
            o.r = 1'b0; o.g = 1'b0; o.b = 1'b0;
        end
        return o;
    endfunction

    task automatic compare(input out_t ex, input string tag);
        out_t o0, o1, ex1;
        o0 = {hs0, vs0, act0, ls0, fs0, r0, g0, b0, x0, y0};
        o1 = {hs1, vs1, act1, ls1, fs1, r1, g1, b1, x1, y1};
        ex1 = ex;
        ex1.hs = ~ex.hs;
        ex1.vs = ~ex.vs;
        total++;
        assert (o0 === ex) else begin
            bad++;
            $error("FAIL %s pol0: observed %h expected %h (x=%0d y=%0d)", tag, o0, ex, ex.x, ex.y);
        end
        total++;
        assert (o1 === ex1) else begin
            bad++;
            $error("FAIL %s pol1: observed %h expected %h (x=%0d y=%0d)", tag, o1, ex1, ex.x, ex.y);
        end
        if (fs0) begin
            if (last_fs >= 0) period = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    task automatic step(input logic e, input string tag);
        out_t ex;
        en = e;
        if (e) begin
            if (mh == 0 && mv == 0) mpat = pattern;
            ex = model_pix(mh, mv, mpat);
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end else begin
            ex = last_exp;
            ex.ls = 1'b0;
            ex.fs = 1'b0;
        end
        last_exp = ex;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        cyc++;
        compare(sb.pop_front(), tag);
    endtask

    task automatic model_reset();
        sb.delete();
        mh = 0;
        mv = 0;
        mpat = 2'd0;
        last_exp = reset_out();
    endtask

    initial begin
        nRst = 1'b0;
        en = 1'b0;
        pattern = 2'd0;
        model_reset();
        #12;
        compare(reset_out(), "reset");
        @(posedge clk);
        #1;
        nRst = 1'b1;

        // Bars frame, pattern switched to grid mid-frame (must not tear).
        for (int i = 0; i < HT * VT; i++) begin
            if (i == 50) pattern = 2'd1;
            step(1'b1, "bars");
        end
        for (int i = 0; i < HT * VT; i++) step(1'b1, "grid");
        total++;
        assert (period === HT * VT) else begin
            bad++;
            $error("FAIL frame_period: observed %0d expected %0d", period, HT * VT);
        end

        pattern = 2'd2;
        for (int i = 0; i < HT * VT; i++) step(1'b1, "white");
        pattern = 2'd3;
        for (int i = 0; i < HT * VT; i++) step(1'b1, "black");

        // Half-rate pixel enable doubles the frame period.
        pattern = 2'd0;
        last_fs = -1;
        period = 0;
        for (int i = 0; i < 4 * HT * VT; i++) step(1'(i % 2 == 0), "en_toggle");
        total++;
        assert (period === 2 * HT * VT) else begin
            bad++;
            $error("FAIL frame_period_half: observed %0d expected %0d", period, 2 * HT * VT);
        end

        // Asynchronous reset right after pixel (5,2) is on the pins.
        for (int i = 0; i < 200 && !(mh == 6 && mv == 2); i++) step(1'b1, "to_5_2");
        #1;
        nRst = 1'b0;
        #1;
        model_reset();
        compare(reset_out(), "async_reset");
        en = 1'b1;
        @(posedge clk);
        #1;
        compare(reset_out(), "reset_hold");
        nRst = 1'b1;
        for (int i = 0; i < 2 * HT; i++) step(1'b1, "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
